// File: rtl/io_button_debouncer.sv
// Push-button debouncer with a two-flop synchronizer, press strobe, switch capture and a press counter.
// Define IO_DEBOUNCE_BYPASS_EN to drop the stable-count wait states and react on the first synchronized edge.
module io_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                btn_pulse,
  output logic                btn_level,
  output logic [SW_WIDTH-1:0] sw_data,
  output logic [15:0]         press_count
);

  logic                btn_meta_q;
  logic                btn_sync_q;
  logic [SW_WIDTH-1:0] sw_meta_q;
  logic [SW_WIDTH-1:0] sw_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sw_raw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  logic                btn_pulse_q, btn_pulse_d;
  logic                btn_level_q, btn_level_d;
  logic [SW_WIDTH-1:0] sw_data_q, sw_data_d;
  logic [15:0]         press_count_q, press_count_d;

`ifdef IO_DEBOUNCE_BYPASS_EN

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  state_t state_q, state_d;

  always_comb begin
    state_d       = state_q;
    btn_pulse_d   = 1'b0;
    sw_data_d     = sw_data_q;
    press_count_d = press_count_q;
    case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d       = PRESSED;
          btn_pulse_d   = 1'b1;
          sw_data_d     = sw_sync_q;
          press_count_d = press_count_q + 16'd1;
        end
      end
      PRESSED: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    btn_level_d = (state_d == PRESSED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      btn_pulse_q   <= 1'b0;
      btn_level_q   <= 1'b0;
      sw_data_q     <= '0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      btn_pulse_q   <= btn_pulse_d;
      btn_level_q   <= btn_level_d;
      sw_data_q     <= sw_data_d;
      press_count_q <= press_count_d;
    end
  end

`else

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    btn_pulse_d   = 1'b0;
    sw_data_d     = sw_data_q;
    press_count_d = press_count_q;
    case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Press confirmed: strobe, capture and count on the same edge.
          state_d       = PRESSED;
          btn_pulse_d   = 1'b1;
          sw_data_d     = sw_sync_q;
          press_count_d = press_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high resumes the held press without a new strobe.
        if (btn_sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_pulse_q   <= 1'b0;
      btn_level_q   <= 1'b0;
      sw_data_q     <= '0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_pulse_q   <= btn_pulse_d;
      btn_level_q   <= btn_level_d;
      sw_data_q     <= sw_data_d;
      press_count_q <= press_count_d;
    end
  end

`endif

  assign btn_pulse   = btn_pulse_q;
  assign btn_level   = btn_level_q;
  assign sw_data     = sw_data_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_io_button_debouncer.sv
// Randomized bench for io_button_debouncer against a run-length reference model.
// Build with IO_DEBOUNCE_BYPASS_EN defined to exercise the bypass variant.
module tb_io_button_debouncer;

  localparam int D  = 4;
  localparam int SW = 8;
`ifdef IO_DEBOUNCE_BYPASS_EN
  localparam int THR = 1;
  localparam int GLITCH_PULSES = 1;
`else
  localparam int THR = D + 1;
  localparam int GLITCH_PULSES = 0;
`endif
  // Two synchronizer edges, then THR consecutive differing samples.
  localparam int LAT  = THR + 2;
  localparam int FALL = THR + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_raw;
  logic [SW-1:0] sw_raw;
  logic          btn_pulse;
  logic          btn_level;
  logic [SW-1:0] sw_data;
  logic [15:0]   press_count;

  io_button_debouncer #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_pulse(btn_pulse), .btn_level(btn_level), .sw_data(sw_data),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw inputs delayed two samples; level flips after THR
  // consecutive synchronized samples that disagree with the current level.
  logic          m_b1, m_b2;
  logic [SW-1:0] m_s1, m_s2;
  logic          m_level, m_pulse;
  int            m_run;
  logic [SW-1:0] m_sw;
  logic [15:0]   m_cnt;

  int edge_no, pulses, last_pulse_edge, fall_edge;
  logic prev_level;

  task automatic model_clear();
    m_b1 = 0; m_b2 = 0; m_s1 = '0; m_s2 = '0;
    m_level = 0; m_pulse = 0; m_run = 0; m_sw = '0; m_cnt = '0;
  endtask

  task automatic model_edge(input logic b, input logic [SW-1:0] s);
    m_pulse = 1'b0;
    if (m_b2 != m_level) m_run++;
    else m_run = 0;
    if (m_run == THR) begin
      m_level = m_b2;
      m_run   = 0;
      if (m_b2) begin
        m_pulse = 1'b1;
        m_sw    = m_s2;
        m_cnt   = m_cnt + 16'd1;
      end
    end
    m_b2 = m_b1; m_b1 = b;
    m_s2 = m_s1; m_s1 = s;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic b, input logic [SW-1:0] s);
    btn_raw = b;
    sw_raw  = s;
    @(posedge clk);
    #1;
    model_edge(b, s);
    edge_no++;
    check_eq("pulse", btn_pulse, m_pulse);
    check_eq("level", btn_level, m_level);
    check_eq("sw_data", sw_data, m_sw);
    check_eq("press_count", press_count, m_cnt);
    if (btn_pulse) begin
      pulses++;
      last_pulse_edge = edge_no;
    end
    if (prev_level && !btn_level) fall_edge = edge_no;
    prev_level = btn_level;
    @(negedge clk);
  endtask

  task automatic hold(input logic b, input logic [SW-1:0] s, input int n);
    for (int i = 0; i < n; i++) step(b, s);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_eq("rst_pulse", btn_pulse, 0);
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_sw_data", sw_data, 0);
    check_eq("rst_count", press_count, 0);
    model_clear();
    prev_level = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int a_edge;

  initial begin
    rst_n = 1'b0; btn_raw = 1'b0; sw_raw = '0;
    model_clear();
    edge_no = 0; pulses = 0; last_pulse_edge = -1; fall_edge = -1; prev_level = 0;
    @(negedge clk);
    do_reset(2);

    // Clean press with sw=0xA5
    edge_no = 0; pulses = 0;
    hold(1'b1, 8'hA5, 20);
    check_eq("clean_latency", last_pulse_edge, LAT);
    check_eq("clean_npulse", pulses, 1);
    check_eq("clean_sw", sw_data, 8'hA5);
    check_eq("clean_count", press_count, 1);
    a_edge = edge_no + 1;
    hold(1'b0, 8'h11, 12);
    check_eq("clean_fall", fall_edge - a_edge, FALL - 1);

    // Short glitch
    do_reset(1);
    pulses = 0;
    hold(1'b1, 8'h77, 3);
    hold(1'b0, 8'h77, 12);
    check_eq("glitch_npulse", pulses, GLITCH_PULSES);

    // Release bounce
    hold(1'b1, 8'h5A, 10);
    pulses = 0;
    hold(1'b0, 8'h00, 2);
    hold(1'b1, 8'h00, 1);
    a_edge = edge_no + 1;
    hold(1'b0, 8'h00, 12);
    check_eq("bounce_npulse", pulses, GLITCH_PULSES);
    check_eq("bounce_fall", fall_edge - a_edge, FALL - 1);

    // Reset in the middle of a press
    hold(1'b1, 8'hC3, 4);
    do_reset(2);
    edge_no = 0; pulses = 0;
    hold(1'b1, 8'hC3, 12);
    check_eq("rstmid_latency", last_pulse_edge, LAT);
    check_eq("rstmid_npulse", pulses, 1);
    hold(1'b0, 8'h00, 12);

    // Counter wrap
    force dut.press_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.press_count_q;
    m_cnt = 16'hFFFF;
    hold(1'b1, 8'h3C, 10);
    check_eq("wrap_count", press_count, 16'h0000);
    check_eq("wrap_sw", sw_data, 8'h3C);
    hold(1'b0, 8'h00, 12);

    // Single-cycle press
    pulses = 0;
    hold(1'b1, 8'h3C, 1);
    hold(1'b0, 8'h00, 10);
    check_eq("short_npulse", pulses, (THR == 1) ? 1 : 0);

    // Randomized bursts with occasional resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        logic b;
        int   len;
        b   = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 2 * D + 4);
        for (int k = 0; k < len; k++) step(b, SW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_button_debouncer.md
IO_BUTTON_DEBOUNCER -- requirements
Module: io_button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-sample count (10 ms at 100 MHz); legal values are >= 2.
REQ-002 SHALL have parameter SW_WIDTH, default 8, giving the switch bus width.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 SHALL have port btn_raw, input, 1 bit, the raw asynchronous confirm button.
REQ-006 SHALL have port sw_raw, input, SW_WIDTH bits, the raw asynchronous switch bank.
REQ-007 SHALL have port btn_pulse, output, 1 bit, a one-cycle strobe per confirmed press.
REQ-008 SHALL have port btn_level, output, 1 bit, the debounced button level.
REQ-009 SHALL have port sw_data, output, SW_WIDTH bits, the switch value captured at the press.
REQ-010 SHALL have port press_count, output, 16 bits, the number of confirmed presses.

Function
REQ-011 SHALL pass btn_raw and sw_raw through two clk flops each (btn_sync, sw_sync) before any other use.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus counter cnt of width $clog2(DEBOUNCE_CYCLES).
REQ-013 IDLE SHALL go to PRESS_WAIT with cnt=0 when btn_sync=1, and otherwise stay in IDLE.
REQ-014 PRESS_WAIT SHALL return to IDLE on btn_sync=0.
REQ-015 PRESS_WAIT SHALL go to PRESSED when btn_sync=1 and cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-016 PRESSED SHALL go to RELEASE_WAIT with cnt=0 when btn_sync=0, and otherwise stay in PRESSED.
REQ-017 RELEASE_WAIT SHALL return to PRESSED on btn_sync=1 (no new pulse).
REQ-018 RELEASE_WAIT SHALL go to IDLE when btn_sync=0 and cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-019 On the PRESS_WAIT->PRESSED edge, the block SHALL register btn_pulse=1, sw_data=sw_sync and press_count+1, all in the same cycle.
REQ-020 btn_pulse SHALL be high for exactly one cycle per press, however long the button is held.
REQ-021 Latency: btn_pulse SHALL be visible after clock edge DEBOUNCE_CYCLES+3, counted from the first edge that samples btn_raw=1 held stable.
REQ-022 btn_level SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-023 sw_data SHALL hold its value between presses.
REQ-024 press_count SHALL wrap from 0xFFFF to 0x0000.
REQ-025 Any btn_sync glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no change to sw_data or press_count.
REQ-026 Changes on sw_raw while the FSM is not on the PRESS_WAIT->PRESSED edge SHALL not affect any output.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, all sync flops=0, btn_pulse=0, btn_level=0, sw_data=0 and press_count=0.
REQ-028 Reset asserted mid-press SHALL abort the press with no pulse.
REQ-029 After rst_n deasserts, a held button SHALL be treated as a new press, so a pulse follows REQ-021 timing.

Configuration
REQ-030 Macro IO_DEBOUNCE_BYPASS_EN, when defined, SHALL remove PRESS_WAIT and RELEASE_WAIT and cnt.
REQ-031 With IO_DEBOUNCE_BYPASS_EN, IDLE SHALL go to PRESSED (with the REQ-019 actions) on btn_sync=1, and PRESSED SHALL go to IDLE on btn_sync=0, giving a pulse 3 edges after the sample.
REQ-032 Without IO_DEBOUNCE_BYPASS_EN, the full four-state debounce of REQ-013..REQ-018 SHALL be built.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=8, bypass off unless noted)
REQ-033 Clean press: sw_raw=0xA5, btn_raw held 20 cycles -> single btn_pulse after edge 7, sw_data=0xA5, press_count=1, btn_level=1 until 4 stable-low cycles after release.
REQ-034 Glitch: btn_raw high 3 cycles then low -> no btn_pulse, press_count=0, sw_data=0x00.
REQ-035 Release bounce: after a confirmed press, btn_raw low 2 cycles, high 1 cycle, then low -> no second pulse; btn_level returns to 0 only 4 cycles after the final low sample.
REQ-036 Reset mid-press: rst_n=0 during PRESS_WAIT with btn held, rst_n=1 two cycles later -> all outputs 0 immediately, then one pulse 7 edges after the first post-reset sample.
REQ-037 Wrap: preload press_count=0xFFFF (force), then one press -> press_count=0x0000.
REQ-038 Bypass: define IO_DEBOUNCE_BYPASS_EN, sw_raw=0x3C, btn_raw high 1 cycle -> btn_pulse after edge 3, sw_data=0x3C.
